// File: rtl/tgl_pkg.sv
// ---------------------------------------------------------------------------
// tgl_pkg
// Shared types and helpers for the toggle bank arbiter.
//   tgl_state_e : FSM state encoding (IDLE / SEL / APPLY)
//   tgl_dbg_t   : debug snapshot of the arbiter (state, pointer, mreg != 0)
//   idx_w()     : index width for n requesters ($clog2, minimum 1)
//   wrap_inc()  : round-robin index increment with wrap at n-1 -> 0
// ---------------------------------------------------------------------------
package tgl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        APPLY = 2'd2
    } tgl_state_e;

    // Widest requester count the block supports; sizes the debug pointer.
    localparam int NREQ_MAX = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    localparam int DBG_PTRW = idx_w(NREQ_MAX);

    // Fixed-width view so the struct does not depend on NREQ or W.
    typedef struct packed {
        tgl_state_e          state;
        logic [DBG_PTRW-1:0] ptr;
        logic                mreg_nz;
    } tgl_dbg_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req (minus any excluded
// requesters) starting at ptr, ascending, wrapping NREQ-1 -> 0; the first
// set bit wins.
//   req   in  [NREQ]  request levels
//   ptr   in  [IDXW]  search start index (must be < NREQ)
//   excl  in  [NREQ]  requesters to ignore in this search
//   valid out         a winner exists
//   idx   out [IDXW]  winner index (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    input  logic [NREQ-1:0] excl,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    logic [NREQ-1:0]   cand;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;

    assign cand = req & ~excl;
    assign dbl  = {cand, cand};
    // rot[k] is the candidate at position (ptr + k) mod NREQ.
    assign rot  = NREQ'(dbl >> ptr);

    // Walk from the far end so the lowest offset is the last (winning) write.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                idx   = IDXW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/toggle_bank_arbiter.sv
// ---------------------------------------------------------------------------
// toggle_bank_arbiter
// Sole writer of a W-bit bank of toggle cells shared by NREQ requesters.
// A round-robin arbiter picks one requester, its mask is latched, XORed into
// the bank, and the winner gets a one-cycle grant pulse.
//
// Optional feature macro: TGL_STAT_EN adds the CNTW parameter and the
// saturating toggle_count output (non-zero masks applied).
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   clr          in   synchronous clear of bank, FSM and counter (ptr kept)
//   req          in   [NREQ]    request levels
//   mask         in   [NREQ*W]  packed masks, requester i at [i*W +: W]
//   gnt          out  [NREQ]    registered one-hot grant pulse
//   q            out  [W]       registered bank contents
//   busy         out            FSM not in IDLE
//   toggle_count out  [CNTW]    only with TGL_STAT_EN
//   dbg          out            state / ptr / mreg-nonzero snapshot
//
// Handshake: a requester holds req and its mask stable until it sees its
// gnt pulse. The mask is sampled on the edge leaving SEL; that same edge
// updates q and raises gnt, so both are visible during APPLY, two cycles
// after req is first seen in IDLE. After gnt the requester may drop req or
// keep it high (with a new mask) to queue another toggle; during APPLY its
// own req is ignored so others are served first.
// ---------------------------------------------------------------------------
module toggle_bank_arbiter
    import tgl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
`ifdef TGL_STAT_EN
    ,
    parameter int CNTW = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] mask,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      q,
    output logic              busy,
`ifdef TGL_STAT_EN
    output logic [CNTW-1:0]   toggle_count,
`endif
    output tgl_dbg_t          dbg
);

    localparam int IDXW = idx_w(NREQ);

    tgl_state_e      state_q;
    tgl_state_e      state_d;
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] win_q;
    logic [IDXW-1:0] pick_idx;
    logic            pick_valid;
    logic [NREQ-1:0] excl;
    logic [W-1:0]    mreg;
    logic [W-1:0]    mask_sel;

    // ptr already points past the winner while in APPLY (it advances on the
    // SEL->APPLY edge), so the search start is always ptr_q; only the
    // winner itself has to be masked out.
    assign excl = (state_q == APPLY) ? (NREQ'(1) << win_q) : '0;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .excl  (excl),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign mask_sel = mask[int'(win_q)*W +: W];

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = SEL;
            SEL:     state_d = APPLY;
            APPLY:   state_d = pick_valid ? SEL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // -----------------------------------------------------------------------
    // State register and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            mreg    <= '0;
            q       <= '0;
            gnt     <= '0;
        end else if (clr) begin
            // Aborts any in-flight selection without a grant; ptr is kept
            // so the aborted requester is re-arbitrated from the same spot.
            state_q <= IDLE;
            mreg    <= '0;
            q       <= '0;
            gnt     <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= '0;
            if (state_d == SEL) begin
                win_q <= pick_idx;
            end
            if (state_q == SEL) begin
                mreg  <= mask_sel;
                q     <= q ^ mask_sel;
                gnt   <= NREQ'(1) << win_q;
                ptr_q <= IDXW'(wrap_inc(int'(win_q), NREQ));
            end
        end
    end

`ifdef TGL_STAT_EN
    // -----------------------------------------------------------------------
    // Saturating count of non-zero masks, bumped while the applied mask is
    // held in mreg (visible the cycle after the grant).
    // -----------------------------------------------------------------------
    logic [CNTW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (state_q == APPLY && mreg != '0 && cnt_q != '1) begin
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign toggle_count = cnt_q;
`endif

    always_comb begin
        dbg         = '0;
        dbg.state   = state_q;
        dbg.ptr     = DBG_PTRW'(ptr_q);
        dbg.mreg_nz = |mreg;
    end

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_toggle_bank_arbiter
// Directed bench for toggle_bank_arbiter (NREQ=4, W=8; CNTW=2 when
// TGL_STAT_EN is defined so saturation is reachable). A transaction-level
// model tracks the bank, pointer and pending winner and is compared with the
// DUT every cycle; literal expectations pin grant order, latency and values.
// ---------------------------------------------------------------------------
module tb_toggle_bank_arbiter;
    import tgl_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int CNTW = 2;
    localparam int CMAX = (1 << CNTW) - 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic [NREQ-1:0]   req  = '0;
    logic [NREQ*W-1:0] mask = '0;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      q;
    logic              busy;
    tgl_dbg_t          dbg;
`ifdef TGL_STAT_EN
    logic [CNTW-1:0]   toggle_count;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    toggle_bank_arbiter #(
        .NREQ (NREQ),
        .W    (W)
`ifdef TGL_STAT_EN
        ,
        .CNTW (CNTW)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .req          (req),
        .mask         (mask),
        .gnt          (gnt),
        .q            (q),
        .busy         (busy),
`ifdef TGL_STAT_EN
        .toggle_count (toggle_count),
`endif
        .dbg          (dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Requester search: first asserted request at or after start, wrapping.
    function automatic int rr_find(input logic [NREQ-1:0] r, input int start, input int skip);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (start + k) % NREQ;
            if (r[i] && i != skip) return i;
        end
        return -1;
    endfunction

    logic [W-1:0]    m_q      = '0;
    logic [NREQ-1:0] m_gnt    = '0;
    logic [W-1:0]    m_mk     = '0;
    int              m_ptr    = 0;
    int              m_chosen = -1;  // requester selected, grant due next edge
    int              m_last   = 0;   // requester granted most recently
    bit              m_just   = 1'b0; // a grant is being shown this cycle
    bit              m_nz     = 1'b0;
    int              m_cnt    = 0;
    bit              m_busy   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = '0; m_gnt = '0; m_ptr = 0; m_chosen = -1;
            m_last = 0; m_just = 1'b0; m_nz = 1'b0; m_cnt = 0;
        end else if (clr) begin
            m_q = '0; m_gnt = '0; m_chosen = -1; m_just = 1'b0; m_cnt = 0;
        end else begin
            m_gnt = '0;
            if (m_just) begin
                m_just = 1'b0;
                if (m_nz && m_cnt < CMAX) m_cnt++;
                m_chosen = rr_find(req, m_ptr, m_last);
            end else if (m_chosen >= 0) begin
                m_mk     = mask[m_chosen*W +: W];
                m_q      = m_q ^ m_mk;
                m_gnt    = NREQ'(1) << m_chosen;
                m_ptr    = (m_chosen + 1) % NREQ;
                m_last   = m_chosen;
                m_nz     = (m_mk != '0);
                m_chosen = -1;
                m_just   = 1'b1;
            end else begin
                m_chosen = rr_find(req, m_ptr, -1);
            end
        end
        m_busy = (m_chosen >= 0) || m_just;
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        bit ok;
        #2;
        ok = (gnt === m_gnt) && (q === m_q) && (busy === m_busy);
`ifdef TGL_STAT_EN
        ok = ok && (toggle_count === CNTW'(m_cnt));
`endif
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL cycle_cmp cyc=%0d: got gnt=%b q=%h busy=%b, want gnt=%b q=%h busy=%b",
                     cyc, gnt, q, busy, m_gnt, m_q, m_busy);
`ifdef TGL_STAT_EN
            $display("FAIL cycle_cmp_cnt cyc=%0d: got count=%0d, want %0d", cyc, toggle_count, m_cnt);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    int             glog[$];
    int             gcyc[$];
    logic [3:0]     exp_q[$];

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for n grants (bounded); optionally drop the granted requester's req.
    task automatic run_grants(input int n, input bit drop, input int budget);
        int got = 0;
        int t = 0;
        while (got < n && t < budget) begin
            @(negedge clk);
            t++;
            if (gnt != '0) begin
                glog.push_back(oh_idx(gnt));
                gcyc.push_back(cyc);
                got++;
                if (drop) req = req & ~gnt;
            end
        end
        if (got < n) chk("grant_timeout", got, n);
    endtask

    task automatic check_order(input string name);
        chk({name, "_len"}, glog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < glog.size(); i++)
            chk(name, glog[i], exp_q[i]);
        glog.delete();
        gcyc.delete();
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic single(input logic [W-1:0] m);
        mask[W-1:0] = m;
        req = 4'b0001;
        run_grants(1, 1'b1, 8);
        step(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        // Reset state
        step(3);
        chk("rst_q", q, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg.state, IDLE);
        chk("rst_ptr", dbg.ptr, 0);
        rst_n = 1'b1;
        step(2);

        // Single request, twice
        mask = 32'h0000_00A5;
        req  = 4'b0001;
        t0   = cyc;
        run_grants(1, 1'b0, 8);
        if (gcyc.size() > 0) chk("single_latency", gcyc[0] - t0, 2);
        chk("single_q1", q, 8'hA5);
        run_grants(1, 1'b1, 8);
        chk("single_q2", q, 8'h00);
        exp_q.push_back(0); exp_q.push_back(0);
        check_order("single_order");
        step(3);

        // Round robin, all four held from ptr=0
        pulse_reset();
        mask = 32'h8844_2211;
        req  = 4'b1111;
        run_grants(5, 1'b0, 20);
        req  = '0;
        chk("rr_q", q, 8'hEE);
        for (int i = 0; i + 1 < gcyc.size(); i++) chk("rr_interval", gcyc[i+1] - gcyc[i], 2);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        check_order("rr_order");
        step(3);

        // Zero mask from requester 2 (moves ptr to 3), then wrap and skip
        mask = 32'h0000_000F;
        req  = 4'b0100;
        run_grants(1, 1'b1, 8);
        chk("zero_mask_q", q, 8'hEE);
        step(2);
        chk("wrap_ptr", dbg.ptr, 3);
        mask = 32'h00F0_000F;
        req  = 4'b0111;
        step(1);
        req[1] = 1'b0;
        run_grants(2, 1'b1, 12);
        chk("wrap_q", q, 8'h11);
        exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
        check_order("wrap_order");
        step(3);

        // clr during SEL
        mask = 32'h0000_3C00;
        req  = 4'b0010;
        step(1);
        chk("clr_in_sel", dbg.state, SEL);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_gnt", gnt, 0);
        chk("clr_q", q, 0);
        chk("clr_busy", busy, 0);
        chk("clr_ptr", dbg.ptr, 3);
        run_grants(1, 1'b1, 8);
        chk("clr_regrant_q", q, 8'h3C);
        exp_q.push_back(1);
        check_order("clr_order");
        step(3);

        // Counter: 01, 00, FF then three more non-zero masks
        pulse_reset();
        single(8'h01);
        single(8'h00);
        single(8'hFF);
        step(1);
`ifdef TGL_STAT_EN
        chk("count_two", toggle_count, 2);
`endif
        single(8'h80);
        single(8'h40);
        single(8'h20);
        step(1);
`ifdef TGL_STAT_EN
        chk("count_sat", toggle_count, CMAX);
`endif
        chk("count_q", q, 8'h1E);

        // Asynchronous reset during APPLY
        mask = 32'h0000_00FF;
        req  = 4'b0001;
        run_grants(1, 1'b1, 8);
        chk("apply_q", q, 8'hE1);
        chk("apply_gnt", gnt, 4'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_q", q, 0);
        chk("async_gnt", gnt, 0);
        chk("async_busy", busy, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        glog.delete();
        gcyc.delete();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/toggle_bank_arbiter.md
Name: toggle_bank_arbiter

Overview:
- Shares one W-bit bank of toggle cells (T-type storage, q <= q ^ t) among NREQ requesters.
- Each requester submits a toggle mask. A round-robin arbiter selects one requester and applies its mask to the bank.
- The block is the sole writer of the bank. It sits between the control agents and the toggle-cell state they share.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, bank width in bits (number of toggle cells).
- CNTW, 16, width of the toggle-event counter (used only with TGL_STAT_EN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of bank and arbitration state.
- req  input  NREQ  per-requester request level.
- mask  input  NREQ*W  packed masks; requester i occupies bits [i*W +: W].
- gnt  output  NREQ  one-hot, one-cycle grant pulse (registered).
- q  output  W  current bank contents (registered).
- busy  output  1  high while the FSM is not in IDLE.
- toggle_count  output  CNTW  number of non-zero masks applied (present only with TGL_STAT_EN).

Behaviour:
- Reset (rst_n low, asynchronous): q=0, gnt=0, busy=0, ptr=0, state=IDLE, latched mask=0, toggle_count=0.
- FSM states:
  - IDLE: if any req is high, pick winner and go to SEL; otherwise stay.
  - SEL: latch mask of winner into mreg, record winner index, go to APPLY. busy=1.
  - APPLY: q <= q ^ mreg; gnt[winner] pulses this cycle. ptr <= (winner+1) mod NREQ. Go to SEL if any req other than the winner is high, else IDLE.
- Arbitration:
  - Search starts at ptr, ascends, and wraps at NREQ-1 -> 0. The first set req wins.
  - Only the winner is ever granted.
  - Winner selection is combinational from req in IDLE/APPLY and is registered on entry to SEL.
- Handshake:
  - A requester holds req and mask stable until it sees its gnt pulse.
  - The mask is sampled in SEL, not at the gnt edge.
  - The requester drops req in the cycle after gnt, or keeps it high to queue another toggle with a new mask.
  - In APPLY, the winner's own req is ignored for the next-state decision, so it cannot be re-granted back-to-back while others wait.
- Latency and throughput:
  - The q update and gnt appear 2 cycles after req is first seen in IDLE.
  - Sustained throughput is one grant per 2 cycles.
- Zero mask: the grant is still issued, q is unchanged, and it is not counted.
- Request withdrawn while waiting: a requester dropping req before selection is simply skipped. A withdrawal after SEL has no effect; the latched mask is still applied.
- clr:
  - Highest priority. Next edge gives q=0, mreg=0, state=IDLE, gnt=0, toggle_count=0.
  - ptr is preserved.
  - Any in-flight grant is aborted without a gnt pulse; the requester must keep req high and is re-arbitrated.
- Single requester: NREQ=1 degenerates correctly, with ptr fixed at 0.
- Reset mid-operation: asynchronous return to the reset values above. No partial toggle is applied.

Optional Feature:
- Macro: TGL_STAT_EN.
- With the macro defined:
  - toggle_count increments by 1 in each APPLY with mreg != 0.
  - It saturates at 2^CNTW-1.
  - It is cleared by rst_n or clr.
- Without the macro: the toggle_count port and its counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package tgl_pkg holds:
  - state enum (IDLE=2'd0, SEL=2'd1, APPLY=2'd2);
  - localparam IDXW = $clog2(NREQ) (minimum 1);
  - a function for wrap-around index increment.
- One natural sub-module: rr_pick, a combinational round-robin selector.
  - Inputs: req, ptr, exclude-mask.
  - Outputs: valid and winner index.
- The top module holds the FSM, mreg, the q bank and the counter.

Test Plan:
- Reset: assert rst_n=0 mid-APPLY -> q=0, gnt=0, busy=0 immediately, without waiting for a clock edge.
- Single request: req=4'b0001, mask0=8'hA5 from q=0 -> gnt=4'b0001 two cycles later; q=8'hA5. Repeat -> q=8'h00.
- Round-robin fairness: req=4'b1111 held, all masks distinct -> grant order 0,1,2,3,0 with one grant every 2 cycles; q equals the XOR of the applied masks.
- Wrap and skip: ptr=3, req=4'b0101 -> grant 0 then 2; a requester that drops req before SEL is never granted.
- clr collision: clr asserted during SEL with req=4'b0010 held -> no gnt, q=0, ptr unchanged. Requester 1 is granted after re-arbitration.
- TGL_STAT_EN: apply masks 8'h01, 8'h00, 8'hFF -> toggle_count=2. With CNTW=2, five non-zero masks -> toggle_count=3 (saturated).
